// File: rtl/reg_write_scoreboard.sv
// Pending-register-write scoreboard: per-register in-flight counters fed by
// ID issue, WB commit and squash events, with a combinational RAW hazard query.
module reg_write_scoreboard #(
    parameter int NUM_REGS  = 16,
    parameter int REG_W     = 4,
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue_valid,
    input  logic                     issue_wb_en,
    input  logic [REG_W-1:0]         issue_dest,
    input  logic                     kill_valid,
    input  logic [REG_W-1:0]         kill_dest,
    input  logic                     wb_valid,
    input  logic [REG_W-1:0]         wb_dest,
    input  logic [REG_W-1:0]         src1,
    input  logic [REG_W-1:0]         src2,
    input  logic                     two_src,
    output logic                     hazard,
    output logic [NUM_REGS-1:0]      busy_mask,
    output logic [REG_W+CNT_W-1:0]   inflight_total,
    output logic                     sb_error
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int TOT_W   = REG_W + CNT_W;

    logic [CNT_W-1:0]    count_q [NUM_REGS];
    logic [CNT_W-1:0]    count_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [TOT_W-1:0]    total_q, total_d;
    logic                err_q, err_d;
    logic                issue_ev_s, issue_ok_s, kill_ok_s, wb_ok_s;
    logic                range_err_s, sat_err_s;
    logic                pend1_s, pend2_s;
    int                  nxt_v;

    // A register still counts as pending unless its last write commits this very cycle.
    function automatic logic pend_f(input logic [CNT_W-1:0] cnt,
                                    input logic [REG_W-1:0] idx,
                                    input logic             wbv,
                                    input logic [REG_W-1:0] wbd);
        return (cnt != CNT_W'(0)) &&
               !((WB_BYPASS != 0) && wbv && (wbd == idx) && (cnt == CNT_W'(1)));
    endfunction

    // Qualify events and flag any destination outside the tracked register range.
    always_comb begin
        issue_ev_s  = issue_valid & issue_wb_en;
        issue_ok_s  = issue_ev_s && (int'(issue_dest) < NUM_REGS);
        kill_ok_s   = kill_valid && (int'(kill_dest) < NUM_REGS);
        wb_ok_s     = wb_valid && (int'(wb_dest) < NUM_REGS);
        range_err_s = (issue_ev_s && !issue_ok_s) ||
                      (kill_valid && !kill_ok_s) ||
                      (wb_valid && !wb_ok_s);
    end

    // Net per-register update with saturation at both ends, plus the derived summaries.
    always_comb begin
        sat_err_s = 1'b0;
        busy_d    = '0;
        total_d   = '0;
        nxt_v     = 0;
        for (int r = 0; r < NUM_REGS; r++) begin
            nxt_v = int'(count_q[r])
                  + ((issue_ok_s && (int'(issue_dest) == r)) ? 1 : 0)
                  - ((kill_ok_s  && (int'(kill_dest)  == r)) ? 1 : 0)
                  - ((wb_ok_s    && (int'(wb_dest)    == r)) ? 1 : 0);
            if (nxt_v > CNT_MAX) begin
                count_d[r] = CNT_W'(CNT_MAX);
                sat_err_s  = 1'b1;
            end else if (nxt_v < 0) begin
                count_d[r] = CNT_W'(0);
                sat_err_s  = 1'b1;
            end else begin
                count_d[r] = CNT_W'(nxt_v);
            end
            busy_d[r] = (count_d[r] != CNT_W'(0));
            total_d   = total_d + TOT_W'(count_d[r]);
        end
        err_d = err_q | sat_err_s | range_err_s;
    end

    // State registers; the error flag is sticky until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= CNT_W'(0);
            end
            busy_q  <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                count_q[r] <= count_d[r];
            end
            busy_q  <= busy_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    // Out-of-range sources never stall.
    always_comb begin
        if (int'(src1) < NUM_REGS) begin
            pend1_s = pend_f(count_q[src1], src1, wb_valid, wb_dest);
        end else begin
            pend1_s = 1'b0;
        end
        if (int'(src2) < NUM_REGS) begin
            pend2_s = pend_f(count_q[src2], src2, wb_valid, wb_dest);
        end else begin
            pend2_s = 1'b0;
        end
        hazard = !rst && (pend1_s || (two_src && pend2_s));
    end

    assign busy_mask      = busy_q;
    assign inflight_total = total_q;
    assign sb_error       = err_q;

endmodule
